// File: rtl/sdio_pkg.sv
// Shared SD-bus definitions: frame geometry, CRC7 polynomial, command-line
// transmitter state encoding and a serial CRC7 step function (also used by
// the response receiver).
package sdio_pkg;

  localparam int unsigned SD_FRAME_LEN = 48;
  localparam int unsigned SD_HEAD_LEN  = 40;
  localparam logic [6:0]  SD_CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_SHIFT,
    S_STOP
  } tx_state_t;

  // One CRC7 step, data bit presented MSB first.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sdio_clk_gen.sv
// SD clock divider: sdio_clk = clk / (2*DIV_HALF).
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   sdio_clk divided clock, low in reset, first rises DIV_HALF clks after release
//   fall_stb high in the clk cycle whose rising edge drives sdio_clk 1->0
//   rise_stb high in the clk cycle whose rising edge drives sdio_clk 0->1
module sdio_clk_gen #(
  parameter int unsigned DIV_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sdio_clk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam logic [7:0] LAST = 8'(DIV_HALF - 1);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sdio_clk <= 1'b0;
    end else if (wrap) begin
      cnt      <= '0;
      sdio_clk <= ~sdio_clk;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Strobes announce the edge that the next clk rising edge will produce.
  assign fall_stb = wrap & sdio_clk;
  assign rise_stb = wrap & ~sdio_clk;

endmodule

// File: rtl/sdio_cmd_tx.sv
// SD-bus CMD line transmitter with integrated SD clock generator.
// Serialises {0, 1, index[5:0], argument[31:0], crc7[6:0], 1} MSB first,
// changing the line only on sdio_clk falling edges.
// Ports:
//   clk, rst_n         system clock; rst_n is an ACTIVE-HIGH async reset
//   sdio_clk           SD card clock (free running)
//   sdio_cmd_i         CMD pad input (reserved for the response receiver)
//   sdio_cmd_o/_oen    CMD pad data / drive enable (1 = drive)
//   i_en, i_cmd, i_para  request strobe, command index, argument
//   o_busy, o_done     frame in progress / one-clk completion pulse
module sdio_cmd_tx
  import sdio_pkg::*;
#(
  parameter int unsigned DIV_HALF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        sdio_clk,
  input  logic        sdio_cmd_i,
  output logic        sdio_cmd_o,
  output logic        sdio_cmd_oen,
  input  logic        i_en,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_para,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [5:0] LAST_BIT = 6'(SD_FRAME_LEN - 1);

  logic fall_stb;
  logic rise_stb;

  sdio_clk_gen #(.DIV_HALF(DIV_HALF)) u_clk_gen (
    .clk      (clk),
    .rst      (rst_n),
    .sdio_clk (sdio_clk),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  logic unused_ok;
  assign unused_ok = sdio_cmd_i ^ rise_stb;

  tx_state_t                state, state_nxt;
  logic [SD_FRAME_LEN-1:0]  shreg, shreg_nxt;
  logic [5:0]               bitcnt, bitcnt_nxt;
  logic                     cmd_nxt, oen_nxt, busy_nxt, done_nxt;
  logic [SD_HEAD_LEN-1:0]   head;
  logic [6:0]               crc;

  assign head = {1'b0, 1'b1, i_cmd, i_para};

  // CRC7 is folded in at capture so the whole frame lives in one shift register.
  always_comb begin
    crc = '0;
    for (int unsigned i = 0; i < SD_HEAD_LEN; i++)
      crc = crc7_next(crc, head[SD_HEAD_LEN-1-i]);
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    cmd_nxt    = sdio_cmd_o;
    oen_nxt    = sdio_cmd_oen;
    busy_nxt   = o_busy;
    done_nxt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_en) begin
          state_nxt  = S_WAIT_EDGE;
          shreg_nxt  = {head, crc, 1'b1};
          bitcnt_nxt = '0;
          busy_nxt   = 1'b1;
        end
      end
      S_WAIT_EDGE: begin
        if (fall_stb) begin
          state_nxt = S_SHIFT;
          cmd_nxt   = shreg[SD_FRAME_LEN-1];
          oen_nxt   = 1'b1;
          shreg_nxt = {shreg[SD_FRAME_LEN-2:0], 1'b1};
        end
      end
      S_SHIFT: begin
        if (fall_stb) begin
          if (bitcnt == LAST_BIT) begin
            state_nxt = S_STOP;
            cmd_nxt   = 1'b1;
            oen_nxt   = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            cmd_nxt    = shreg[SD_FRAME_LEN-1];
            shreg_nxt  = {shreg[SD_FRAME_LEN-2:0], 1'b1};
            bitcnt_nxt = bitcnt + 6'd1;
          end
        end
      end
      S_STOP: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      bitcnt       <= '0;
      sdio_cmd_o   <= 1'b1;
      sdio_cmd_oen <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bitcnt       <= bitcnt_nxt;
      sdio_cmd_o   <= cmd_nxt;
      sdio_cmd_oen <= oen_nxt;
      o_busy       <= busy_nxt;
      o_done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sdio_cmd_tx.sv
// Directed bench for sdio_cmd_tx: two instances (DIV_HALF=2 and 1) share the
// clock and reset; a select muxes which one is driven and observed.
module tb_sdio_cmd_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        en  = 1'b0;
  logic [5:0]  cmd = '0;
  logic [31:0] para = '0;

  logic sclk0, cmdo0, oen0, busy0, done0;
  logic sclk1, cmdo1, oen1, busy1, done1;
  logic en0, en1;
  logic ob_sclk, ob_cmd, ob_oen, ob_busy, ob_done;

  always #5 clk = ~clk;

  assign en0 = en & ~sel;
  assign en1 = en & sel;
  assign ob_sclk = sel ? sclk1 : sclk0;
  assign ob_cmd  = sel ? cmdo1 : cmdo0;
  assign ob_oen  = sel ? oen1  : oen0;
  assign ob_busy = sel ? busy1 : busy0;
  assign ob_done = sel ? done1 : done0;

  sdio_cmd_tx #(.DIV_HALF(2)) dut (
    .clk(clk), .rst_n(rst), .sdio_clk(sclk0), .sdio_cmd_i(1'b1),
    .sdio_cmd_o(cmdo0), .sdio_cmd_oen(oen0), .i_en(en0), .i_cmd(cmd),
    .i_para(para), .o_busy(busy0), .o_done(done0)
  );

  sdio_cmd_tx #(.DIV_HALF(1)) dut1 (
    .clk(clk), .rst_n(rst), .sdio_clk(sclk1), .sdio_cmd_i(1'b1),
    .sdio_cmd_o(cmdo1), .sdio_cmd_oen(oen1), .i_en(en1), .i_cmd(cmd),
    .i_para(para), .o_busy(busy1), .o_done(done1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] f_bits;
  int          f_nbits, f_oen, f_done, f_bad;
  logic        f_tmo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one request on the selected instance and records what the card would
  // see: bits sampled on sdio_clk rising edges while driven, driven clk count,
  // done pulses and CMD changes not aligned to an sdio_clk fall.
  task automatic run_frame(input logic [5:0] c_cmd, input logic [31:0] c_para,
                           input int en_len, input int inj_at,
                           input bit en_on_done, input int rst_at);
    logic pclk, pcmd, seen_busy;
    f_bits = '0; f_nbits = 0; f_oen = 0; f_done = 0; f_bad = 0; f_tmo = 1'b1;
    pclk = ob_sclk; pcmd = ob_cmd; seen_busy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      en   = (c < en_len) || (c == inj_at) || (en_on_done && ob_done);
      cmd  = (c == inj_at) ? 6'd55 : c_cmd;
      para = (c == inj_at) ? 32'hDEAD_BEEF : c_para;
      @(posedge clk); #1;
      if (ob_oen)  f_oen++;
      if (ob_done) f_done++;
      if (!pclk && ob_sclk && ob_oen) begin
        f_bits = {f_bits[46:0], ob_cmd};
        f_nbits++;
      end
      if ((ob_cmd !== pcmd) && !(pclk && !ob_sclk)) f_bad++;
      pclk = ob_sclk;
      pcmd = ob_cmd;
      if (ob_busy) seen_busy = 1'b1;
      if (rst_at >= 0 && f_nbits == rst_at) begin
        rst = 1'b1;
        #1;
        check("midrst oen",  64'(ob_oen),  64'd0);
        check("midrst cmd",  64'(ob_cmd),  64'd1);
        check("midrst sclk", 64'(ob_sclk), 64'd0);
        check("midrst busy", 64'(ob_busy), 64'd0);
        check("midrst done", 64'(ob_done), 64'd0);
        f_tmo = 1'b0;
        break;
      end
      if (seen_busy && !ob_busy) begin
        f_tmo = 1'b0;
        break;
      end
    end
    en = 1'b0;
    check("frame timeout", 64'(f_tmo), 64'd0);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp, input int oen_exp);
    check({tag, " bits"},  64'(f_bits),  64'(exp));
    check({tag, " nbits"}, 64'(f_nbits), 64'd48);
    check({tag, " oen"},   64'(f_oen),   64'(oen_exp));
    check({tag, " done"},  64'(f_done),  64'd1);
    check({tag, " edges"}, 64'(f_bad),   64'd0);
    check({tag, " idle"},  64'({ob_oen, ob_cmd, ob_busy, ob_done}), 64'b0100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst dut",  64'({sclk0, cmdo0, oen0, busy0, done0}), 64'b01000);
    check("rst dut1", 64'({sclk1, cmdo1, oen1, busy1, done1}), 64'b01000);

    rst = 1'b0;
    @(posedge clk); #1;
    check("sclk1 dut",  64'(sclk0), 64'd0);
    check("sclk1 dut1", 64'(sclk1), 64'd1);
    @(posedge clk); #1;
    check("sclk2 dut",  64'(sclk0), 64'd1);
    check("sclk2 dut1", 64'(sclk1), 64'd0);
    repeat (3) @(posedge clk); #1;

    // CMD0 with a 2-clk request strobe
    run_frame(6'd0, 32'h0, 2, -1, 1'b0, -1);
    check_frame("cmd0", 48'h40_0000_0000_95, 192);

    // CMD17; request re-asserted in the done cycle must be ignored
    run_frame(6'd17, 32'h0, 1, -1, 1'b1, -1);
    check_frame("cmd17", 48'h51_0000_0000_55, 192);
    repeat (3) @(posedge clk); #1;
    check("done-cycle req ignored", 64'(ob_busy), 64'd0);

    run_frame(6'd8, 32'h0000_01AA, 1, -1, 1'b0, -1);
    check_frame("cmd8", 48'h48_0000_01AA_87, 192);

    // CMD55 strobe mid-frame, then immediate re-request
    run_frame(6'd0, 32'h0, 1, 60, 1'b0, -1);
    check_frame("cmd0 inj", 48'h40_0000_0000_95, 192);
    run_frame(6'd8, 32'h0000_01AA, 1, -1, 1'b0, -1);
    check_frame("cmd8 rereq", 48'h48_0000_01AA_87, 192);

    // Reset at bit 20
    run_frame(6'd0, 32'h0, 1, -1, 1'b0, 20);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("post-rst idle", 64'({ob_oen, ob_cmd, ob_busy, ob_done}), 64'b0100);
    run_frame(6'd0, 32'h0, 1, -1, 1'b0, -1);
    check_frame("cmd0 after rst", 48'h40_0000_0000_95, 192);

    // DIV_HALF = 1 instance
    sel = 1'b1;
    #1;
    run_frame(6'd0, 32'h0, 1, -1, 1'b0, -1);
    check_frame("div1 cmd0", 48'h40_0000_0000_95, 96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdio_cmd_tx.md
Name: sdio_cmd_tx

Overview:
- SD-bus command-line transmitter with an integrated SD clock generator.
- Divides the system clock down to sdio_clk.
- On a one-cycle request, serialises a 48-bit SD command frame onto the CMD line: start, tx bit, index, argument, CRC7, end.
- Sits between the SD host controller FSM and the CMD pad tristate buffer.

Parameters:
- DIV_HALF, default 2: number of clk cycles per sdio_clk half-period. sdio_clk = clk/(2*DIV_HALF). Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous reset, ACTIVE-HIGH despite the _n suffix.
- sdio_clk  out  1  SD card clock, free-running after reset.
- sdio_cmd_i  in  1  CMD pad input; unused by this block, reserved for the response receiver.
- sdio_cmd_o  out  1  CMD pad output data.
- sdio_cmd_oen  out  1  CMD pad output enable; 1 = block drives the pad.
- i_en  in  1  request strobe, sampled on the clk rising edge.
- i_cmd  in  6  command index.
- i_para  in  32  command argument.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-clk pulse when the frame completes.

Behaviour:
- Reset values (while rst_n=1): sdio_clk=0, sdio_cmd_o=1, sdio_cmd_oen=0, o_busy=0, o_done=0. All counters are cleared and the FSM returns to IDLE. Reset mid-frame aborts immediately with no done pulse.
- Clock generation:
  - A counter 0..DIV_HALF-1 toggles sdio_clk on wrap.
  - fall_stb is high in the clk cycle in which sdio_clk goes 1->0.
  - sdio_clk first rises DIV_HALF clk cycles after reset release.
- FSM states: IDLE, WAIT_EDGE, SHIFT, STOP.
- IDLE:
  - sdio_cmd_o=1, oen=0.
  - i_en=1 captures i_cmd and i_para and builds the 40-bit head = {0, 1, i_cmd, i_para}.
  - The transition to WAIT_EDGE sets o_busy=1 on the next clk.
- WAIT_EDGE: on fall_stb, go to SHIFT. sdio_cmd_o=0 (start bit) and oen=1 are asserted in the same clk edge on which sdio_clk falls.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the 40 head bits MSB first. It may be computed serially during the shift or combinationally at capture; either way, the value must be ready before bit 40.
- SHIFT:
  - Frame = {head[39:0], crc7[6:0], 1}, sent MSB first.
  - Each bit is updated only on fall_stb and held for exactly 2*DIV_HALF clk cycles, so the card samples it on the sdio_clk rising edge.
  - The bit counter runs 0..47. After bit 47 (end bit=1), the next fall_stb enters STOP.
- STOP:
  - On that same edge: oen=0, sdio_cmd_o=1, o_done=1 for one clk.
  - Next clk: o_busy=0, return to IDLE.
- Request rules:
  - i_en while o_busy=1 is ignored; it is neither queued nor allowed to corrupt the captured fields.
  - i_en held high for several cycles starts exactly one frame.
  - i_en asserted in the same cycle o_done pulses is ignored. A new frame can be accepted the cycle after o_busy falls.
- Latency: capture to start bit ≤ 2*DIV_HALF clk. Start bit to oen release = 48 sdio_clk periods exactly.
- sdio_clk never stops or stretches during a frame.

Decomposition:
- Shared package sdio_pkg:
  - SD_FRAME_LEN=48, SD_HEAD_LEN=40, SD_CRC7_POLY=7'h09.
  - FSM state enum typedef.
  - A crc7_next(crc, bit) function, reused later by the response receiver.
- One sub-module, sdio_clk_gen: DIV_HALF divider that outputs sdio_clk, fall_stb and rise_stb.
- Top-level sdio_cmd_tx holds the FSM, shift register and CRC.

Test Plan:
- CMD0: i_en pulse of 2 clk, i_cmd=0, i_para=0, DIV_HALF=2. The CMD line sampled on sdio_clk rising edges must read 48'h40_0000_0000_95. oen is high for exactly 48*4=192 clk. One o_done pulse follows.
- CMD17 with i_para=0 -> frame 48'h51_0000_0000_55. CMD8 with i_para=32'h0000_01AA -> frame 48'h48_0000_01AA_87.
- Every sdio_cmd_o transition coincides with a sdio_clk falling edge. No change occurs within 1 clk of any rising edge.
- An i_en pulse with i_cmd=55 mid-frame during CMD0 -> CMD0 frame unchanged, only one o_done. An immediate re-request after o_busy falls starts a second, correct frame.
- Assert rst_n=1 at bit 20 -> same cycle: oen=0, cmd_o=1, sdio_clk=0, o_busy=0, no o_done. After release, a new CMD0 transmits correctly.
- DIV_HALF=1 -> sdio_clk = clk/2, CMD0 frame still 48'h40_0000_0000_95, oen high for 96 clk.
